output_scheduler: RTL and testbench

OUTPUT_SCHEDULER -- requirements
Module: output_scheduler

---
 rtl/output_scheduler_pkg.sv | 28 ++
 rtl/output_scheduler_arbiter.sv | 42 ++++
 rtl/output_scheduler.sv | 127 ++++++++++++
 tb/tb_output_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_scheduler_pkg
// Description : Shared constants, FSM state type and fill clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package output_scheduler_pkg;

  localparam int NUM_QUEUES = 4;
  localparam int PKT_W      = 4;
  localparam int FULL_W     = 3;
  localparam int MAX_FILL   = 6;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    READ   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Encodings above MAX_FILL are reserved; they rank as a full queue.
  function automatic logic [FULL_W-1:0] clamp_fill(input logic [FULL_W-1:0] fill);
    return (fill > FULL_W'(MAX_FILL)) ? FULL_W'(MAX_FILL) : fill;
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : max_fill_arbiter
// Description : Picks the fullest queue; ties go round-robin after pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module max_fill_arbiter
  import output_scheduler_pkg::*;
(
  input  logic [NUM_QUEUES*FULL_W-1:0] fullness_bus,
  input  logic [IDX_W-1:0]             pointer,
  output logic [IDX_W-1:0]             winner,
  output logic                         any_nonempty
);

  logic [FULL_W-1:0] w_fill [NUM_QUEUES];
  logic [FULL_W-1:0] w_best_val;
  logic [IDX_W-1:0]  w_idx;

  generate
    for (genvar k = 0; k < NUM_QUEUES; k++) begin : g_clamp
      assign w_fill[k] = clamp_fill(fullness_bus[k*FULL_W +: FULL_W]);
    end
  endgenerate

  // Scanning from pointer+1 with a strict compare makes the earliest tied queue win.
  always_comb begin
    winner     = pointer + IDX_W'(1);
    w_best_val = '0;
    w_idx      = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      w_idx = pointer + IDX_W'(i + 1);
      if (w_fill[w_idx] > w_best_val) begin
        w_best_val = w_fill[w_idx];
        winner     = w_idx;
      end
    end
    any_nonempty = (w_best_val != '0);
  end

endmodule
`default_nettype wire

// File: rtl/output_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : output_scheduler
// Description : Periodically dequeues one packet from the fullest of 4 queues.
// Revision    : 1.0 - initial release
// ============================================================================
module output_scheduler
  import output_scheduler_pkg::*;
#(
  parameter int PERIOD = 25000000,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [NUM_QUEUES*FULL_W-1:0] fullness_bus,
  input  logic [NUM_QUEUES*PKT_W-1:0]  head_bus,
  output logic [NUM_QUEUES-1:0]        read,
  output logic [PKT_W-1:0]             pkt_out,
  output logic                         pkt_valid,
  output logic [IDX_W-1:0]             src_id,
  output logic                         skip,
  output logic [CNT_W-1:0]             served0,
  output logic [CNT_W-1:0]             served1,
  output logic [CNT_W-1:0]             served2,
  output logic [CNT_W-1:0]             served3
);

  localparam int                  c_PCNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]    c_SRV_MAX  = '1;

  state_t               r_state;
  state_t               w_next;
  logic [c_PCNT_W-1:0]  r_pcnt;
  logic [IDX_W-1:0]     r_winner;
  logic [IDX_W-1:0]     r_src_id;
  logic [IDX_W-1:0]     w_arb_winner;
  logic                 w_any;
  logic                 w_expire;
  logic [PKT_W-1:0]     r_pkt_out;
  logic [CNT_W-1:0]     r_served [NUM_QUEUES];

  max_fill_arbiter u_arbiter (
    .fullness_bus (fullness_bus),
    .pointer      (r_winner),
    .winner       (w_arb_winner),
    .any_nonempty (w_any)
  );

  assign w_expire = en && (r_pcnt == c_PCNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Strobes decode straight from the state register so reset clears them at once.
  always_comb begin
    w_next    = r_state;
    read      = '0;
    skip      = 1'b0;
    pkt_valid = 1'b0;
    case (r_state)
      IDLE:   if (w_expire) w_next = SELECT;
      SELECT: begin
        if (w_any) begin
          w_next = READ;
        end else begin
          skip   = 1'b1;
          w_next = IDLE;
        end
      end
      READ: begin
        read   = NUM_QUEUES'(1) << r_winner;
        w_next = DONE;
      end
      DONE: begin
        pkt_valid = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (r_state == IDLE && en) begin
      r_pcnt <= w_expire ? '0 : r_pcnt + c_PCNT_W'(1);
    end
  end

  // r_winner doubles as the round-robin pointer; reset to the last queue so queue 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_winner  <= IDX_W'(NUM_QUEUES - 1);
      r_src_id  <= '0;
      r_pkt_out <= '0;
    end else begin
      if (r_state == SELECT && w_any) r_winner <= w_arb_winner;
      if (r_state == READ) begin
        r_pkt_out <= head_bus[r_winner*PKT_W +: PKT_W];
        r_src_id  <= r_winner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_QUEUES; k++) r_served[k] <= '0;
    end else if (r_state == DONE) begin
      for (int k = 0; k < NUM_QUEUES; k++) begin
        if (r_src_id == IDX_W'(k) && r_served[k] != c_SRV_MAX) r_served[k] <= r_served[k] + CNT_W'(1);
      end
    end
  end

  assign pkt_out = r_pkt_out;
  assign src_id  = r_src_id;
  assign served0 = r_served[0];
  assign served1 = r_served[1];
  assign served2 = r_served[2];
  assign served3 = r_served[3];

endmodule
`default_nettype wire

// File: tb/tb_output_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_scheduler
// Description : Vector table, corner sequences and random run against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_scheduler;

  localparam int PERIOD = 4;
  localparam int CNT_W  = 2;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [11:0]      fullness_bus = '0;
  logic [15:0]      head_bus = '0;
  logic [3:0]       read;
  logic [3:0]       pkt_out;
  logic             pkt_valid;
  logic [1:0]       src_id;
  logic             skip;
  logic [CNT_W-1:0] served0, served1, served2, served3;

  int total = 0;
  int bad   = 0;

  int m_wait, m_after, m_last, m_win, m_pkt, m_src;
  int m_served [4];

  typedef struct {
    logic [11:0] f;
    logic [15:0] h;
    int          win;
    bit          empty;
  } vec_t;
  vec_t tbl [7];

  logic [3:0] rd [8];
  logic       vl [8];
  logic       sk [8];

  output_scheduler #(.PERIOD(PERIOD), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .fullness_bus (fullness_bus),
    .head_bus     (head_bus),
    .read         (read),
    .pkt_out      (pkt_out),
    .pkt_valid    (pkt_valid),
    .src_id       (src_id),
    .skip         (skip),
    .served0      (served0),
    .served1      (served1),
    .served2      (served2),
    .served3      (served3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] served_of(input int k);
    case (k)
      0:       return served0;
      1:       return served1;
      2:       return served2;
      default: return served3;
    endcase
  endfunction

  function automatic int fill_of(input logic [11:0] f, input int k);
    int v;
    v = int'(f[3*k +: 3]);
    return (v > 6) ? 6 : v;
  endfunction

  // Largest clamped fill; among equals, the one closest after the last winner.
  function automatic int pick(input logic [11:0] f, input int last);
    int best, bestv, bestd;
    best = 0; bestv = -1; bestd = 4;
    for (int k = 0; k < 4; k++) begin
      int v, d;
      v = fill_of(f, k);
      d = (k - last + 3) % 4;
      if (v > bestv || (v == bestv && d < bestd)) begin
        best = k; bestv = v; bestd = d;
      end
    end
    return best;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_wait = 0; m_after = 0; m_last = 3; m_win = 0; m_pkt = 0; m_src = 0;
    for (int k = 0; k < 4; k++) m_served[k] = 0;
  endtask

  // m_after counts cycles since the period expired (0 = still waiting).
  task automatic model_check();
    int exp_read;
    exp_read = (m_after == 2) ? (1 << m_win) : 0;
    check("rand_read", 32'(read), 32'(exp_read));
    check("rand_skip", 32'(skip), 32'((m_after == 1 && fullness_bus == 12'd0) ? 1 : 0));
    check("rand_valid", 32'(pkt_valid), 32'((m_after == 3) ? 1 : 0));
    check("rand_pkt", 32'(pkt_out), 32'(m_pkt));
    check("rand_src", 32'(src_id), 32'(m_src));
    for (int k = 0; k < 4; k++) check("rand_served", 32'(served_of(k)), 32'(m_served[k]));
  endtask

  task automatic model_step();
    logic [15:0] h;
    h = head_bus;
    case (m_after)
      0: if (en) begin
        m_wait++;
        if (m_wait == PERIOD) begin m_wait = 0; m_after = 1; end
      end
      1: if (fullness_bus == 12'd0) m_after = 0;
         else begin m_win = pick(fullness_bus, m_last); m_last = m_win; m_after = 2; end
      2: begin m_pkt = int'(h[4*m_win +: 4]); m_src = m_win; m_after = 3; end
      default: begin
        if (m_served[m_win] < SAT) m_served[m_win]++;
        m_after = 0;
      end
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  other;
    logic [15:0] hv;
    logic [11:0] f;
    int          nread, lat;
    logic [3:0]  seen [$];

    tbl[0] = '{{3'd0, 3'd1, 3'd5, 3'd2}, {4'h3, 4'h2, 4'hA, 4'h1}, 1, 1'b0};
    tbl[1] = '{{3'd0, 3'd7, 3'd0, 3'd6}, {4'h4, 4'h9, 4'h8, 4'h7}, 0, 1'b0};
    tbl[2] = '{{3'd7, 3'd0, 3'd6, 3'd0}, {4'hE, 4'h5, 4'hF, 4'h2}, 1, 1'b0};
    tbl[3] = '{{3'd1, 3'd0, 3'd0, 3'd0}, {4'hC, 4'h0, 4'h0, 4'h0}, 3, 1'b0};
    tbl[4] = '{{3'd0, 3'd0, 3'd0, 3'd0}, {4'h5, 4'h6, 4'h7, 4'h8}, 0, 1'b1};
    tbl[5] = '{{3'd5, 3'd4, 3'd2, 3'd5}, {4'h6, 4'hB, 4'hD, 4'h9}, 0, 1'b0};
    tbl[6] = '{{3'd1, 3'd6, 3'd3, 3'd0}, {4'h1, 4'h5, 4'h2, 4'h3}, 2, 1'b0};

    apply_reset();
    check("reset_read", 32'(read), 0);
    check("reset_pkt", 32'(pkt_out), 0);
    check("reset_valid", 32'(pkt_valid), 0);
    check("reset_src", 32'(src_id), 0);
    check("reset_skip", 32'(skip), 0);
    for (int k = 0; k < 4; k++) check("reset_served", 32'(served_of(k)), 0);

    for (int t = 0; t < 7; t++) begin
      en = 1'b1;
      fullness_bus = tbl[t].f;
      head_bus = tbl[t].h;
      apply_reset();
      for (int k = 1; k < 8; k++) begin
        tick();
        rd[k] = read; vl[k] = pkt_valid; sk[k] = skip;
      end
      other = '0;
      for (int k = 1; k < 8; k++) if (k != 5) other |= rd[k];
      check("vec_read_other", 32'(other), 0);
      if (tbl[t].empty) begin
        check("vec_skip", 32'(sk[4]), 1);
        check("vec_read_none", 32'(rd[5]), 0);
        check("vec_valid_none", 32'(vl[6]), 0);
        for (int k = 0; k < 4; k++) check("vec_served_none", 32'(served_of(k)), 0);
      end else begin
        hv = tbl[t].h;
        check("vec_read", 32'(rd[5]), 32'(1 << tbl[t].win));
        check("vec_noskip", 32'(sk[4]), 0);
        check("vec_valid", 32'(vl[6]), 1);
        check("vec_pkt", 32'(pkt_out), 32'(hv[4*tbl[t].win +: 4]));
        check("vec_src", 32'(src_id), 32'(tbl[t].win));
        check("vec_served", 32'(served_of(tbl[t].win)), 1);
      end
    end

    // Equal fill: winners rotate 0,1,2,3.
    en = 1'b1; fullness_bus = {4{3'd3}}; head_bus = 16'h4321;
    apply_reset();
    seen.delete();
    for (int c = 0; c < 40 && seen.size() < 4; c++) begin
      tick();
      if (read != 4'd0) seen.push_back(read);
    end
    check("rr_count", 32'(seen.size()), 4);
    for (int i = 0; i < seen.size(); i++) check("rr_order", 32'(seen[i]), 32'(1 << i));

    // Enable held low, then latency from enable.
    en = 1'b0; fullness_bus = {3'd0, 3'd4, 3'd0, 3'd0};
    apply_reset();
    nread = 0;
    repeat (10) begin tick(); if (read != 4'd0) nread++; end
    check("en_low_noread", 32'(nread), 0);
    en = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (read != 4'd0) begin lat = c; break; end
    end
    check("en_latency", 32'(lat), 32'(PERIOD + 1));
    check("en_read_q2", 32'(read), 32'h4);

    // Served counter saturation.
    en = 1'b1; fullness_bus = 12'd1;
    apply_reset();
    nread = 0;
    repeat (35) begin tick(); if (read != 4'd0) nread++; end
    check("sat_reads", 32'(nread), 5);
    check("sat_served0", 32'(served0), 32'(SAT));
    check("sat_served1", 32'(served1), 0);

    // Asynchronous reset in the middle of a read.
    en = 1'b1; fullness_bus = {3'd0, 3'd0, 3'd5, 3'd0}; head_bus = 16'h00B0;
    apply_reset();
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      if (read != 4'd0) begin lat = 1; break; end
      tick();
    end
    check("midread_reached", 32'(lat), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midread_read", 32'(read), 0);
    check("midread_valid", 32'(pkt_valid), 0);
    check("midread_pkt", 32'(pkt_out), 0);
    check("midread_src", 32'(src_id), 0);
    check("midread_skip", 32'(skip), 0);
    for (int k = 0; k < 4; k++) check("midread_served", 32'(served_of(k)), 0);
    tick();
    rst_n = 1'b1;

    // Random traffic in chunks, each starting from a fresh reset.
    for (int chunk = 0; chunk < 6; chunk++) begin
      en = 1'b0;
      model_reset();
      apply_reset();
      for (int n = 0; n < 500; n++) begin
        en = ($urandom_range(0, 3) != 0);
        f = '0;
        case ($urandom_range(0, 3))
          0: f = '0;
          1: for (int k = 0; k < 4; k++) f[3*k +: 3] = 3'($urandom_range(2, 3));
          2: f = 12'($urandom);
          default: f[3*$urandom_range(0, 3) +: 3] = 3'($urandom_range(1, 7));
        endcase
        fullness_bus = f;
        head_bus = 16'($urandom);
        #1;
        model_check();
        model_step();
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
